// File: rtl/uart_rx_fifo_writer_if.sv
// uart_rx_fifo_writer_if: FIFO write-side bundle between the UART receiver and the byte FIFO
interface uart_rx_fifo_writer_if #(parameter int DATA_BITS = 8);
  logic                 fifo_wr_en;
  logic [DATA_BITS-1:0] fifo_wr_data;
  logic                 fifo_full;
  modport master (output fifo_wr_en, output fifo_wr_data, input fifo_full);
  modport slave  (input fifo_wr_en, input fifo_wr_data, output fifo_full);
endinterface

// File: rtl/uart_rx_fifo_writer.sv
// uart_rx_fifo_writer: 8N1 UART receiver that writes each good byte into a FIFO and flags framing/overrun errors
module uart_rx_fifo_writer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  uart_rx_fifo_writer_if.master        fifo,
  output logic                         busy,
  output logic                         frame_error,
  output logic                         overrun
);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]    LAST = IW'(DATA_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
  state_t               r_state, w_next;
  logic                 r_rx_m, r_rx_s;
  logic [CNT_W-1:0]     r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_sh, r_wr_data;
  logic                 r_wr_en, r_fe, r_ov;
  logic                 w_half, w_full, w_stop, w_bit, w_clr;
  assign w_half = r_cnt == HALF;
  assign w_full = r_cnt == FULL;
  assign w_stop = r_state == S_STOP && w_full;
  assign w_bit  = r_state == S_DATA && w_full;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = r_rx_s ? S_IDLE : S_START;
      S_START: w_next = !w_half ? S_START : (r_rx_s ? S_IDLE : S_DATA);
      S_DATA:  w_next = (w_bit && r_idx == LAST) ? S_STOP : S_DATA;
      S_STOP:  w_next = !w_full ? S_STOP : (r_rx_s ? S_IDLE : S_BRK);
      S_BRK:   w_next = r_rx_s ? S_IDLE : S_BRK;
      default: w_next = S_IDLE;
    endcase
  end
  // the bit counter restarts on every state change and after every data sample
  assign w_clr = r_state == S_IDLE || r_state == S_BRK || r_state != w_next || w_bit;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_m    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_fe      <= 1'b0;
      r_ov      <= 1'b0;
    end else begin
      r_rx_m  <= rx;
      r_rx_s  <= r_rx_m;
      r_cnt   <= w_clr ? '0 : r_cnt + 1'b1;
      r_idx   <= (r_state == S_START) ? '0 : (w_bit ? r_idx + 1'b1 : r_idx);
      r_sh    <= w_bit ? {r_rx_s, r_sh[DATA_BITS-1:1]} : r_sh;
      r_wr_en <= w_stop && r_rx_s && !fifo.fifo_full;
      r_ov    <= w_stop && r_rx_s && fifo.fifo_full;
      r_fe    <= w_stop && !r_rx_s;
      if (w_stop && r_rx_s && !fifo.fifo_full) r_wr_data <= r_sh;
    end
  end
  assign fifo.fifo_wr_en   = r_wr_en;
  assign fifo.fifo_wr_data = r_wr_data;
  assign busy              = r_state != S_IDLE;
  assign frame_error       = r_fe;
  assign overrun           = r_ov;
endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// tb_uart_rx_fifo_writer: scoreboard bench; a frame-level model predicts each output event and its cycle
module tb_uart_rx_fifo_writer;
  localparam int CPB = 16;
  localparam int LAT = 155;
  logic clk = 0, rst = 1, rx = 1;
  logic busy, frame_error, overrun;
  uart_rx_fifo_writer_if #(.DATA_BITS(8)) fif ();
  uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .fifo(fif),
    .busy(busy), .frame_error(frame_error), .overrun(overrun)
  );
  always #5 clk = ~clk;
  typedef struct {int kind; logic [7:0] data; int at;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [7:0] last_wr = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // monitor: every pulse must match the oldest predicted event, in kind, byte and cycle
  logic prev_pulse = 0;
  always @(negedge clk) begin : mon
    int n, kind;
    exp_t e;
    if (rst) prev_pulse = 0;
    else begin
      n = int'(fif.fifo_wr_en) + int'(overrun) + int'(frame_error);
      kind = fif.fifo_wr_en ? 0 : (overrun ? 1 : 2);
      if (n > 1) chk("exclusive_pulses", n, 1);
      if (n > 0) chk("no_consecutive_pulse", int'(prev_pulse), 0);
      if (n > 0) begin
        if (q.size() == 0) chk("unexpected_event_kind", kind, -1);
        else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.at);
          if (e.kind == 0) begin
            chk("wr_data", int'(fif.fifo_wr_data), int'(e.data));
            last_wr = fif.fifo_wr_data;
          end
        end
      end
      prev_pulse = n > 0;
    end
  end
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, int'(fif.fifo_wr_en), 0);
    chk({tag, "_wr_data"}, int'(fif.fifo_wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_error"}, int'(frame_error), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask
  // one 8N1 frame; fifo_full is random except during the stop bit, where it takes full_at_stop
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic full_at_stop);
    exp_t e;
    e.kind = !stop ? 2 : (full_at_stop ? 1 : 0);
    e.data = d;
    e.at   = cyc + LAT;
    q.push_back(e);
    fif.fifo_full = 1'($urandom);
    rx = 0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      fif.fifo_full = 1'($urandom);
      wait_cycles(CPB);
    end
    rx = stop;
    fif.fifo_full = full_at_stop;
    wait_cycles(CPB);
    fif.fifo_full = 0;
  endtask
  initial begin
    logic [7:0] d;
    logic st, fl;
    fif.fifo_full = 0;
    rst = 1;
    wait_cycles(3);
    check_idle_outputs("reset");
    rst = 0;
    wait_cycles(10);
    send_frame(8'h55, 1, 0);
    wait_cycles(20);
    send_frame(8'hA5, 1, 0);
    send_frame(8'h00, 1, 0);
    send_frame(8'hFF, 1, 0);
    wait_cycles(20);
    rx = 0;
    wait_cycles(5);
    rx = 1;
    chk("glitch_busy_high", int'(busy), 1);
    wait_cycles(15);
    chk("glitch_busy_low", int'(busy), 0);
    wait_cycles(10);
    send_frame(8'h3C, 0, 0);
    wait_cycles(400);
    rx = 1;
    wait_cycles(20);
    send_frame(8'h81, 1, 0);
    wait_cycles(10);
    send_frame(8'h7E, 1, 1);
    send_frame(8'h12, 1, 0);
    wait_cycles(10);
    rx = 0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = (8'hC3 >> i) & 1;
      wait_cycles(CPB);
    end
    rst = 1;
    wait_cycles(1);
    check_idle_outputs("midframe_reset");
    last_wr = 0;
    wait_cycles(2);
    rst = 0;
    rx = 1;
    wait_cycles(40);
    chk("post_reset_busy", int'(busy), 0);
    send_frame(8'h99, 1, 0);
    for (int k = 0; k < 25; k++) begin
      d  = 8'($urandom);
      st = $urandom_range(0, 7) != 0;
      fl = $urandom_range(0, 3) == 0;
      send_frame(d, st, fl);
      if (!st) begin
        wait_cycles($urandom_range(1, 300));
        rx = 1;
        wait_cycles(CPB);
      end else if ($urandom_range(0, 2) != 0) wait_cycles($urandom_range(1, 30));
    end
    for (int k = 0; k < 200 && q.size() != 0; k++) wait_cycles(1);
    chk("scoreboard_drained", q.size(), 0);
    chk("wr_data_held", int'(fif.fifo_wr_data), int'(last_wr));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
